state_sequencer: RTL
====================

Name: state_sequencer

Overview:
- Generates the 11-state control sequence (states 0..10) consumed by the state-transition monitor, driving `state` and `old_state` on the shared interface.
- Branch choices come from a select input. A load handshake lets the testbench or a host force a start state.
- Transition and wrap counters, an illegal-state flag and a stall watchdog support coverage and debug.

Parameters:
- SW, 4, state/select-load width in bits (must hold 0..15).
- CW, 16, width of transition and wrap counters.
- STALL_MAX, 8, consecutive adv-low cycles before the timeout pulse (>=1).

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous reset, active-low (asserted when 0, sampled on posedge clk).
- adv  in  1  advance one transition this cycle.
- sel  in  2  branch select for multi-successor states.
- ld_valid  in  1  forced-state load request.
- ld_state  in  SW  state value to load.
- ld_ready  out  1  load accepted when ld_valid & ld_ready.
- state  out  SW  current state.
- old_state  out  SW  state before the most recent update.
- trans_cnt  out  CW  number of state updates since reset, saturating.
- wrap_cnt  out  CW  number of returns to state 0 since reset, saturating.
- err_illegal  out  1  sticky; set when state holds a value >10.
- timeout  out  1  one-cycle pulse on stall watchdog expiry.

Behaviour:
- Reset (rst==0 at posedge):
  - next cycle state=0, old_state=0, trans_cnt=0, wrap_cnt=0, err_illegal=0, timeout=0.
  - stall counter cleared.
  - ld_ready=0 while rst==0.
- Reset dominates everything, including mid-load and mid-sequence; no partial update survives.
- ld_ready = (state==0) & rst, combinational from registers.
- Priority per cycle: reset > load accept > adv > hold.
- Load accept: state<=ld_state, old_state<=state. Values 11..15 are loaded as-is.
- Transition table, applied when adv=1 and no load:
  - 0->1
  - 1->(sel[0]?4:2)
  - 2->3
  - 3->(sel[0]?1:5)
  - 4->5
  - 5->(sel[0]?1:6)
  - 6->7
  - 7->(sel[0]?8:0)
  - 8->{00:2, 01:4, 10:10, 11:9}[sel]
  - 9->(sel[0]?0:8)
  - 10->0
  - 11..15->4, regardless of sel.
- On every update (load or adv), old_state<=state. On hold, both registers keep their values.
- Latency: one cycle from adv/sel sampled to new state visible.
- trans_cnt: +1 on every update; saturates at 2^CW-1.
- wrap_cnt: +1 when an adv transition lands on 0, from 7, 9 or 10. Load to 0 does not count. Saturates.
- err_illegal: set the cycle after state holds >10. Cleared only by reset.
- Stall counter:
  - Counts consecutive cycles with adv=0 and no load.
  - Reaching STALL_MAX gives timeout=1 for exactly one cycle and the counter returns to 0.
  - Any update clears the counter. State is never altered by timeout.
- Simultaneous events:
  - ld_valid & ld_ready & adv: load wins; adv ignored that cycle.
  - ld_valid while ld_ready=0: ignored, no side effects. The requester holds until ready.

Decomposition:
- Package state_seq_pkg:
  - state constants ST0..ST10.
  - ST_DFLT_NEXT=4, ST_MAX_LEGAL=10.
  - sel code constants SEL_A..SEL_D.
  - typedef for the SW-wide state.
- Sub-module seq_next_state: purely combinational next-state lookup (state, sel) -> nxt, matching the transition table.
- state_sequencer holds the registers, handshake, counters and watchdog.

Test Plan:
- Reset: hold rst=0 for 3 cycles mid-sequence at state 6 -> state=0, old_state=0, counters=0, ld_ready=0. Release -> ld_ready=1.
- Main loop: adv=1, sel=0 from reset -> states 0,1,2,3,5,6,7,0; trans_cnt=7, wrap_cnt=1.
- Branches: with adv=1, sel=2'b10 at state 8 -> 10 then 0, wrap_cnt+1. Separately, sel=2'b11 at 8 -> 9, then sel[0]=0 -> 8.
- Illegal load: at state 0, ld_valid=1, ld_state=13 -> state=13, err_illegal=1 next cycle. Next adv -> state 4, err_illegal stays 1.
- Load vs adv collision: at state 0, ld_valid=1, ld_state=8, adv=1 -> state=8 (not 1), old_state=0. ld_valid at state 3 -> no effect.
- Watchdog: STALL_MAX=8, adv=0 for 17 cycles -> timeout pulses at stall cycles 8 and 16 only; state unchanged; trans_cnt unchanged.

Source files
------------

// File: rtl/state_seq_pkg.sv
// Shared constants and types for the 11-state control sequencer.
package state_seq_pkg;

   localparam int STATE_W = 4;

   typedef logic [STATE_W-1:0] state_t;

   localparam state_t ST0  = 4'd0;
   localparam state_t ST1  = 4'd1;
   localparam state_t ST2  = 4'd2;
   localparam state_t ST3  = 4'd3;
   localparam state_t ST4  = 4'd4;
   localparam state_t ST5  = 4'd5;
   localparam state_t ST6  = 4'd6;
   localparam state_t ST7  = 4'd7;
   localparam state_t ST8  = 4'd8;
   localparam state_t ST9  = 4'd9;
   localparam state_t ST10 = 4'd10;

   // Successor used for any out-of-range state, so the sequence always recovers.
   localparam state_t ST_DFLT_NEXT = 4'd4;
   localparam state_t ST_MAX_LEGAL = 4'd10;

   localparam logic [1:0] SEL_A = 2'b00;
   localparam logic [1:0] SEL_B = 2'b01;
   localparam logic [1:0] SEL_C = 2'b10;
   localparam logic [1:0] SEL_D = 2'b11;

endpackage

// File: rtl/state_sequencer_next_state.sv
// Combinational successor lookup for the control sequence.
module seq_next_state
   import state_seq_pkg::*;
#(
   parameter int SW = 4
) (
   input  logic [SW-1:0] state,
   input  logic [1:0]    sel,
   output logic [SW-1:0] nxt
);

   // Successor of the current state; anything outside 0..10 falls back to the default.
   always_comb begin
      nxt = SW'(ST_DFLT_NEXT);
      case (state)
         SW'(ST0):  nxt = SW'(ST1);
         SW'(ST1):  nxt = sel[0] ? SW'(ST4) : SW'(ST2);
         SW'(ST2):  nxt = SW'(ST3);
         SW'(ST3):  nxt = sel[0] ? SW'(ST1) : SW'(ST5);
         SW'(ST4):  nxt = SW'(ST5);
         SW'(ST5):  nxt = sel[0] ? SW'(ST1) : SW'(ST6);
         SW'(ST6):  nxt = SW'(ST7);
         SW'(ST7):  nxt = sel[0] ? SW'(ST8) : SW'(ST0);
         SW'(ST8): begin
            case (sel)
               SEL_A:   nxt = SW'(ST2);
               SEL_B:   nxt = SW'(ST4);
               SEL_C:   nxt = SW'(ST10);
               SEL_D:   nxt = SW'(ST9);
               default: nxt = SW'(ST2);
            endcase
         end
         SW'(ST9):  nxt = sel[0] ? SW'(ST0) : SW'(ST8);
         SW'(ST10): nxt = SW'(ST0);
         default:   nxt = SW'(ST_DFLT_NEXT);
      endcase
   end

endmodule

// File: rtl/state_sequencer.sv
// Control-sequence generator: state registers, load handshake, counters and stall watchdog.
module state_sequencer
   import state_seq_pkg::*;
#(
   parameter int SW        = 4,
   parameter int CW        = 16,
   parameter int STALL_MAX = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          adv,
   input  logic [1:0]    sel,
   input  logic          ld_valid,
   input  logic [SW-1:0] ld_state,
   output logic          ld_ready,
   output logic [SW-1:0] state,
   output logic [SW-1:0] old_state,
   output logic [CW-1:0] trans_cnt,
   output logic [CW-1:0] wrap_cnt,
   output logic          err_illegal,
   output logic          timeout
);

   localparam int STW = $clog2(STALL_MAX + 1);

   logic [SW-1:0]  state_q, state_d;
   logic [SW-1:0]  old_state_q, old_state_d;
   logic [CW-1:0]  trans_cnt_q, trans_cnt_d;
   logic [CW-1:0]  wrap_cnt_q, wrap_cnt_d;
   logic           err_illegal_q, err_illegal_d;
   logic           timeout_q, timeout_d;
   logic [STW-1:0] stall_q, stall_d;
   logic [SW-1:0]  nxt;
   logic           load_acc;

   seq_next_state #(.SW(SW)) u_next (
      .state (state_q),
      .sel   (sel),
      .nxt   (nxt)
   );

   // Loads are only offered at state 0 and never while reset is asserted.
   assign ld_ready = (state_q == SW'(ST0)) & rst;
   assign load_acc = ld_valid & ld_ready;

   // Next-state, counter and watchdog computation; load beats advance, otherwise hold.
   always_comb begin
      state_d       = state_q;
      old_state_d   = old_state_q;
      trans_cnt_d   = trans_cnt_q;
      wrap_cnt_d    = wrap_cnt_q;
      stall_d       = stall_q;
      timeout_d     = 1'b0;
      err_illegal_d = err_illegal_q | (state_q > SW'(ST_MAX_LEGAL));

      if (load_acc) begin
         state_d = ld_state;
      end else if (adv) begin
         state_d = nxt;
         if ((nxt == SW'(ST0)) && (wrap_cnt_q != '1)) begin
            wrap_cnt_d = wrap_cnt_q + 1'b1;
         end
      end

      if (load_acc | adv) begin
         old_state_d = state_q;
         stall_d     = '0;
         if (trans_cnt_q != '1) begin
            trans_cnt_d = trans_cnt_q + 1'b1;
         end
      end else if (stall_q == STW'(STALL_MAX - 1)) begin
         stall_d   = '0;
         timeout_d = 1'b1;
      end else begin
         stall_d = stall_q + 1'b1;
      end
   end

   // Register bank with synchronous active-low reset clearing every piece of state.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q       <= '0;
         old_state_q   <= '0;
         trans_cnt_q   <= '0;
         wrap_cnt_q    <= '0;
         err_illegal_q <= 1'b0;
         timeout_q     <= 1'b0;
         stall_q       <= '0;
      end else begin
         state_q       <= state_d;
         old_state_q   <= old_state_d;
         trans_cnt_q   <= trans_cnt_d;
         wrap_cnt_q    <= wrap_cnt_d;
         err_illegal_q <= err_illegal_d;
         timeout_q     <= timeout_d;
         stall_q       <= stall_d;
      end
   end

   assign state       = state_q;
   assign old_state   = old_state_q;
   assign trans_cnt   = trans_cnt_q;
   assign wrap_cnt    = wrap_cnt_q;
   assign err_illegal = err_illegal_q;
   assign timeout     = timeout_q;

endmodule
